// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request, response and data-memory signals of the load/store unit
// Ports (signals): req_* execute-stage request, resp_* completion, mem_* data memory.
// slave modport is the unit's view; master modport is the surrounding pipeline/memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_store;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport slave (
    input  req_valid, req_addr, req_wdata, req_funct3, req_store, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
  modport master (
    output req_valid, req_addr, req_wdata, req_funct3, req_store, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit with alignment/funct3 checks and memory timeout
// Ports: clk, rst_n (async active-low), bus (load_store_unit_if.slave) carrying the
// execute-stage request, the one-cycle response pulse and the data-memory handshake.
module load_store_unit #(
  parameter int TIMEOUT = 15
) (
  input logic             clk,
  input logic             rst_n,
  load_store_unit_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_store;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_fault;
  logic        w_ok_f3;
  logic        w_misaligned;
  logic        w_bad;
  logic        w_acc;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [31:0] w_load;
  always_comb begin
    w_ok_f3      = bus.req_store ? (bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                                 : (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    // funct3[1:0] encodes the access size for every legal op
    w_misaligned = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
    w_bad        = !w_ok_f3 || w_misaligned;
    w_b          = 8'(bus.mem_rdata >> {r_addr[1:0], 3'b000});
    w_h          = 16'(bus.mem_rdata >> {r_addr[1], 4'b0000});
    w_load       = r_funct3 == 3'b000 ? {{24{w_b[7]}}, w_b} :
                   r_funct3 == 3'b001 ? {{16{w_h[15]}}, w_h} :
                   r_funct3 == 3'b100 ? {24'd0, w_b} :
                   r_funct3 == 3'b101 ? {16'd0, w_h} : bus.mem_rdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_store  <= 1'b0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_addr   <= bus.req_addr;
          r_wdata  <= bus.req_wdata;
          r_funct3 <= bus.req_funct3;
          r_store  <= bus.req_store;
          r_cnt    <= '0;
          r_rdata  <= '0;
          r_fault  <= w_bad;
          r_state  <= w_bad ? S_RESP : S_ACCESS;
        end
        S_ACCESS: if (bus.mem_ack) begin
          r_rdata <= r_store ? '0 : w_load;
          r_fault <= 1'b0;
          r_state <= S_RESP;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          // this cycle is the TIMEOUT-th without ack; an ack here would have won above
          r_fault <= 1'b1;
          r_state <= S_RESP;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign w_acc          = r_state == S_ACCESS;
  assign bus.req_ready  = r_state == S_IDLE;
  assign bus.resp_valid = r_state == S_RESP;
  assign bus.resp_rdata = bus.resp_valid ? r_rdata : '0;
  assign bus.resp_fault = bus.resp_valid & r_fault;
  assign bus.mem_req    = w_acc;
  assign bus.mem_we     = w_acc & r_store;
  assign bus.mem_addr   = w_acc ? {r_addr[31:2], 2'b00} : '0;
  assign bus.mem_be     = !(w_acc && r_store) ? 4'b0000 :
                          r_funct3[1:0] == 2'b00 ? 4'b0001 << r_addr[1:0] :
                          r_funct3[1:0] == 2'b01 ? 4'b0011 << r_addr[1:0] : 4'b1111;
  assign bus.mem_wdata  = !w_acc ? '0 :
                          r_funct3[1:0] == 2'b00 ? {4{r_wdata[7:0]}} :
                          r_funct3[1:0] == 2'b01 ? {2{r_wdata[15:0]}} : r_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random transactions checked against a reference model
module tb_load_store_unit;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  load_store_unit_if bus ();
  load_store_unit #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input bit st, input int f3, input int unsigned addr);
    bit ok;
    ok = st ? (f3 <= 2) : (f3 <= 5 && f3 != 3);
    return ok && (addr % (1 << (f3 % 4))) == 0;
  endfunction

  function automatic logic [31:0] load_val(input int f3, input int unsigned addr, input logic [31:0] word);
    longint nbits, v;
    nbits = 8 * (1 << (f3 % 4));
    v = (longint'(word) >> (8 * (addr % 4))) & ((longint'(1) << nbits) - 1);
    if (f3 < 4 && nbits < 32 && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
    return 32'(v);
  endfunction

  function automatic logic [3:0] exp_be(input int f3, input int unsigned addr);
    return 4'(((1 << (1 << (f3 % 4))) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] exp_wd(input int f3, input logic [31:0] wd);
    return (f3 % 4) == 0 ? 32'((wd % 256) * 32'h0101_0101) :
           (f3 % 4) == 1 ? 32'((wd % 65536) * 32'h0001_0001) : wd;
  endfunction

  // k = number of ACCESS cycles before ack (k >= TO means memory never acks)
  task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rd, input int k);
    bit lg;
    bit ef;
    logic [31:0] erd;
    lg = legal(st, int'(f3), addr);
    ef = !lg;
    erd = '0;
    chk("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    bus.req_funct3 = 3'($urandom);
    if (lg) begin
      for (int c = 0; c < TO; c++) begin
        chk("mem_req", 32'(bus.mem_req), 1);
        chk("req_ready_busy", 32'(bus.req_ready), 0);
        chk("resp_valid_busy", 32'(bus.resp_valid), 0);
        chk("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
        chk("mem_we", 32'(bus.mem_we), 32'(st));
        chk("mem_be", 32'(bus.mem_be), st ? 32'(exp_be(int'(f3), addr)) : 0);
        if (st) chk("mem_wdata", bus.mem_wdata, exp_wd(int'(f3), wd));
        bus.mem_ack = (c == k);
        bus.mem_rdata = (c == k) ? rd : $urandom;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        if (c == k) break;
      end
      ef = k >= TO;
      erd = (st || ef) ? 32'd0 : load_val(int'(f3), addr, rd);
    end
    chk("resp_valid", 32'(bus.resp_valid), 1);
    chk("resp_fault", 32'(bus.resp_fault), 32'(ef));
    chk("resp_rdata", bus.resp_rdata, erd);
    chk("mem_req_resp", 32'(bus.mem_req), 0);
    chk("req_ready_resp", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    chk("resp_one_cycle", 32'(bus.resp_valid), 0);
  endtask

  initial begin
    logic [31:0] a;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_funct3 = '0;
    bus.req_store = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    #2;
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_fault", 32'(bus.resp_fault), 0);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_be", 32'(bus.mem_be), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    txn(0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
    txn(0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 1);
    txn(0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 2);
    txn(1, 3'b001, 32'h0000_0010, 32'h1234_ABCD, 32'h5555_5555, 0);
    txn(1, 3'b000, 32'h0000_0021, 32'hCAFE_F00D, 32'h0, 3);
    txn(1, 3'b010, 32'h0000_0030, 32'hDEAD_BEEF, 32'h0, 1);
    txn(0, 3'b010, 32'h0000_0006, 32'h0, 32'h1111_1111, 0);
    txn(0, 3'b011, 32'h0000_0008, 32'h0, 32'h1111_1111, 0);
    txn(1, 3'b100, 32'h0000_0008, 32'h0, 32'h0, 0);
    txn(0, 3'b001, 32'h0000_0003, 32'h0, 32'h0, 0);
    txn(0, 3'b010, 32'h0000_0100, 32'h0, 32'h7654_3210, TO);
    txn(0, 3'b010, 32'h0000_0100, 32'h0, 32'h7654_3210, TO - 1);
    txn(1, 3'b010, 32'h0000_0104, 32'h0BAD_CAFE, 32'h0, TO);
    bus.req_valid = 1'b1;
    bus.req_store = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h0000_0040;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("pre_reset_mem_req", 32'(bus.mem_req), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", 32'(bus.mem_req), 0);
    chk("async_rst_req_ready", 32'(bus.req_ready), 1);
    chk("async_rst_mem_addr", bus.mem_addr, 0);
    #1 rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("stray_ack_resp", 32'(bus.resp_valid), 0);
    chk("stray_ack_mem_req", 32'(bus.mem_req), 0);
    txn(1, 3'b010, 32'h0000_0200, 32'h0123_4567, 32'h0, 1);
    for (int i = 0; i < 80; i++) begin
      a = $urandom;
      if ($urandom % 2 == 1) a = a & 32'hFFFF_FFFC;
      txn(1'($urandom), 3'($urandom), a, $urandom, $urandom,
          ($urandom % 8 == 0) ? TO : int'($urandom_range(0, 3)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
